// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding a UART transmitter that has no ready output: each popped
// byte is held on txDataOUT and loaded for one baud period inside a 12-baud slot.
module uart_tx_buffer #(
  parameter int unsigned CLOCK_FREQUENCY = 10_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned FIFO_DEPTH      = 16
) (
  input  logic                          clockIN,
  input  logic                          nResetIN,
  input  logic [7:0]                    dataIN,
  input  logic                          writeIN,
  output logic                          fullOUT,
  output logic                          emptyOUT,
  output logic [$clog2(FIFO_DEPTH):0]   countOUT,
  output logic                          overflowOUT,
  output logic                          busyOUT,
  output logic [7:0]                    txDataOUT,
  output logic                          txLoadOUT
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam int unsigned CW        = AW + 1;
  localparam int unsigned BAUD_CLKS = 2 * (CLOCK_FREQUENCY / BAUD_RATE / 2);
  localparam int unsigned SLOT_CLKS = 12 * BAUD_CLKS;
  localparam int unsigned SW        = $clog2(SLOT_CLKS);

  localparam logic [SW-1:0] LOAD_LAST = SW'(BAUD_CLKS - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SLOT_CLKS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic full, empty, push, pop, load;

  always_comb begin
    full  = (count_q == FULL_CNT);
    empty = (count_q == '0);
    // Full check ignores a same-cycle pop, so a write at full is always dropped.
    push  = writeIN && !full;
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = mem_q[rd_ptr_q];
          slot_d    = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load   = 1'b1;
        slot_d = slot_q + 1'b1;
        if (slot_q == LOAD_LAST) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        slot_d = slot_q + 1'b1;
        if (slot_q == SLOT_LAST) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clockIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      slot_q    <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      slot_q    <= slot_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge clockIN) begin
    if (push) mem_q[wr_ptr_q] <= dataIN;
  end

  always_comb begin
    fullOUT     = full;
    emptyOUT    = empty;
    countOUT    = count_q;
    overflowOUT = writeIN && full;
    busyOUT     = (state_q != ST_IDLE);
    txDataOUT   = tx_data_q;
    txLoadOUT   = load;
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: bytes queued on accepted writes are
// popped and compared at each txLoadOUT rise, with slot/load timing checked.
module tb_uart_tx_buffer;

  localparam int unsigned DEPTH     = 16;
  localparam int unsigned BAUD_CLKS = 10;   // 2*(10_000_000/1_000_000/2)
  localparam int unsigned SLOT_CLKS = 120;  // 12*BAUD_CLKS

  logic       clockIN = 1'b0;
  logic       nResetIN = 1'b0;
  logic [7:0] dataIN = '0;
  logic       writeIN = 1'b0;
  logic       fullOUT, emptyOUT, overflowOUT, busyOUT, txLoadOUT;
  logic [4:0] countOUT;
  logic [7:0] txDataOUT;

  uart_tx_buffer #(
    .CLOCK_FREQUENCY(10_000_000),
    .BAUD_RATE      (1_000_000),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clockIN    (clockIN),
    .nResetIN   (nResetIN),
    .dataIN     (dataIN),
    .writeIN    (writeIN),
    .fullOUT    (fullOUT),
    .emptyOUT   (emptyOUT),
    .countOUT   (countOUT),
    .overflowOUT(overflowOUT),
    .busyOUT    (busyOUT),
    .txDataOUT  (txDataOUT),
    .txLoadOUT  (txLoadOUT)
  );

  always #5 clockIN = ~clockIN;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0]  sb[$];
  int          cyc = 0;
  int          rise_cyc = 0;
  int          load_len = 0;
  logic        load_prev = 1'b0;
  logic        busy_prev = 1'b0;
  logic        pend = 1'b0;
  logic [7:0]  cur_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic monitor();
    if (!nResetIN) return;
    if (pend) check("pop_latency", txLoadOUT, 1'b1);
    if (txLoadOUT && !load_prev) begin
      if (sb.size() == 0) begin
        check("unexpected_load", txLoadOUT, 1'b0);
      end else begin
        cur_byte = sb.pop_front();
        check("tx_data", txDataOUT, cur_byte);
      end
      rise_cyc = cyc;
      load_len = 0;
    end
    if (txLoadOUT) begin
      load_len++;
      check("busy_in_load", busyOUT, 1'b1);
    end
    if (!txLoadOUT && load_prev) check("load_len", load_len, BAUD_CLKS);
    if (busyOUT) check("tx_stable", txDataOUT, cur_byte);
    if (!busyOUT && busy_prev) check("slot_len", cyc - rise_cyc, SLOT_CLKS);
    check("count", countOUT, sb.size());
    check("empty", emptyOUT, sb.size() == 0);
    check("full", fullOUT, sb.size() == DEPTH);
    pend      = !busyOUT && (sb.size() != 0);
    load_prev = txLoadOUT;
    busy_prev = busyOUT;
  endtask

  task automatic step();
    @(posedge clockIN);
    #1;
    cyc++;
    monitor();
  endtask

  task automatic wr(input logic [7:0] b);
    logic exp_ovf;
    dataIN  = b;
    writeIN = 1'b1;
    #1;
    exp_ovf = (sb.size() == DEPTH);
    check("overflow", overflowOUT, exp_ovf);
    if (!exp_ovf) sb.push_back(b);
    step();
    writeIN = 1'b0;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    while ((sb.size() != 0 || busyOUT) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_timeout", {31'd0, (sb.size() != 0 || busyOUT)}, 32'd0);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busyOUT && n < max_cycles) begin
      step();
      n++;
    end
    check("idle_timeout", busyOUT, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_load"},  txLoadOUT,   1'b0);
    check({tag, "_count"}, countOUT,    5'd0);
    check({tag, "_empty"}, emptyOUT,    1'b1);
    check({tag, "_full"},  fullOUT,     1'b0);
    check({tag, "_busy"},  busyOUT,     1'b0);
    check({tag, "_ovf"},   overflowOUT, 1'b0);
    check({tag, "_data"},  txDataOUT,   8'h00);
  endtask

  task automatic clear_model();
    sb.delete();
    load_prev = 1'b0;
    busy_prev = 1'b0;
    pend      = 1'b0;
    cur_byte  = '0;
  endtask

  initial begin
    #1;
    check_reset_values("rst");
    repeat (3) step();
    nResetIN = 1'b1;

    // Idle: no loads without writes
    repeat (5000) step();
    check("idle_load", txLoadOUT, 1'b0);

    // Single byte: latency, load length and slot length
    wr(8'hA5);
    check("lat_cnt1", countOUT, 5'd1);
    check("lat_noload", txLoadOUT, 1'b0);
    step();
    check("lat_load", txLoadOUT, 1'b1);
    check("lat_data", txDataOUT, 8'hA5);
    drain(2 * SLOT_CLKS);

    // Three back-to-back bytes
    wr(8'h01);
    wr(8'h02);
    wr(8'h03);
    check("b2b_cnt", countOUT, 5'd2);
    drain(4 * (SLOT_CLKS + 1));

    // Fill while busy, then one dropped write
    wr(8'h80);
    for (int unsigned i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i));
    check("fill_full", fullOUT, 1'b1);
    wr(8'hEE);
    #1;
    check("ovf_pulse_end", overflowOUT, 1'b0);
    drain((DEPTH + 2) * (SLOT_CLKS + 1));
    check("fill_empty", emptyOUT, 1'b1);

    // Write coinciding with pop at count 1, 40 bytes, pointers wrap
    wr(8'hC0);
    wr(8'hC1);
    for (int unsigned i = 2; i < 40; i++) begin
      wait_idle(2 * SLOT_CLKS);
      check("wp_cnt_before", countOUT, 5'd1);
      wr(8'hC0 + 8'(i));
      check("wp_cnt_after", countOUT, 5'd1);
    end
    drain(3 * (SLOT_CLKS + 1));

    // Reset mid-HOLD with 5 bytes queued
    for (int unsigned i = 0; i < 6; i++) wr(8'h10 + 8'(i));
    check("pre_rst_cnt", countOUT, 5'd5);
    repeat (BAUD_CLKS + 20) step();
    check("pre_rst_hold", {30'd0, busyOUT, txLoadOUT}, 32'd2);
    nResetIN = 1'b0;
    #1;
    check_reset_values("async_rst");
    clear_model();
    repeat (3) step();
    nResetIN = 1'b1;
    repeat (300) step();
    check("post_rst_noload", txLoadOUT, 1'b0);
    wr(8'h5A);
    step();
    check("post_rst_data", txDataOUT, 8'h5A);
    drain(2 * SLOT_CLKS);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
